window_fetch_sequencer: RTL and testbench
=========================================

Name: window_fetch_sequencer

Overview:
- Loads one 80x80-byte search image from word-addressed external memory into an internal byte array.
- Then presents successive 16x16-byte windows of that image to a downstream correlator, one per handshake.
- Contains the image-address translation: row/col to a 21-bit word address, 1665-word record layout.
- Sits between the memory read port and the NCC compute block.

Parameters:
- SET_INDEX, 0: record index; record base = SET_INDEX*1665.
- IMG_OFFSET, 65: word offset of image inside a record (word 0 header, words 1..64 template).
- IMG_DIM, 80: image width/height in bytes.
- WORDS_PER_ROW, 20: IMG_DIM/4.
- WIN_DIM, 16: window width/height in bytes.
- STRIDE, 16: window origin step in bytes, both axes.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-high reset (name kept per codebase; asserted = 1).
- en  in  1  start pulse; sampled only in IDLE.
- input_data  in  32  memory read data; valid exactly 1 cycle after addr is presented.
- ack  in  1  downstream has consumed the current window.
- addr  out  21  word read address = SET_INDEX*1665 + IMG_OFFSET + row*WORDS_PER_ROW + col.
- row  out  7  image row being requested (0..79).
- col  out  7  word column being requested (0..19).
- window_data  out  16x16x8  window bytes, [r][c] = image[orig_r+r][orig_c+c].
- window_ready  out  1  window_data valid.
- done  out  1  all windows delivered.
- receive  out  1  one-cycle pulse when image load completes.
- LEDs  out  4  one-hot state: IDLE=0001, LOAD=0010, PRESENT=0100, DONE=1000.

Behaviour:
- Reset:
  - state IDLE; row, col, origins, store pointers = 0.
  - window_ready = done = receive = 0; LEDs = 0001.
  - Image array contents don't care.
  - Reset mid-operation aborts to IDLE immediately.
- IDLE: en=1 -> LOAD with row=col=0. Otherwise hold.
- LOAD, issue side:
  - Each cycle present addr for (row,col), then advance col.
  - col wraps 19->0 with row++.
  - 1600 issues total (row 0..79, col 0..19).
- LOAD, store side:
  - store_row/store_col lag issue by one cycle.
  - Word at (sr,sc) is unpacked into image bytes [sr][4sc..4sc+3].
  - Byte order: input_data[31:24] -> 4sc, [23:16] -> 4sc+1, [15:8] -> 4sc+2, [7:0] -> 4sc+3.
  - The first cycle of LOAD stores nothing.
- LOAD exit:
  - After the final word (79,19) is stored (cycle 1601 of LOAD), pulse receive for 1 cycle.
  - Go to PRESENT with origin (0,0).
  - row/col hold their last value after issue ends.
- PRESENT:
  - window_ready = 1.
  - window_data is combinational from the array at the current origin.
  - Stays valid and stable until ack=1 is sampled.
  - On ack: origin_c += STRIDE. If it exceeds IMG_DIM-WIN_DIM, set origin_c=0 and origin_r += STRIDE.
  - If origin_r also exceeds the limit, go to DONE.
  - window_ready drops for exactly 1 cycle between windows; the next window is valid the following cycle.
  - With defaults there are 25 windows; origins are 0,16,32,48,64 on each axis.
- DONE:
  - done = 1, window_ready = 0; held.
  - en=1 restarts: done cleared, new LOAD.
- en outside IDLE/DONE is ignored.
- ack outside PRESENT is ignored.
- ack held continuously advances one window per 2 cycles.
- Arithmetic:
  - addr computed unsigned, zero-extended to 21 bits.
  - row*20 = (row<<4)+(row<<2).

Test Plan:
- Reset then idle: rst_n=1 for 2 cycles -> window_ready=0, done=0, LEDs=0001, addr=65.
- Address sweep:
  - Memory word 65+k holds k; pulse en.
  - addr steps 65,66,...,1664 on consecutive cycles.
  - receive pulses once, 1601 cycles after LOAD entry.
- Byte unpack: after load, first window [0][0..3] = 00,00,00,00.
  - [0][4..7] = 00,00,00,01.
  - [1][0..3] = 00,00,00,14 (word 20).
- Window walk with ack=1 continuous:
  - 25 windows appear.
  - Second window [0][0..3] = word 4 bytes 00,00,00,04.
  - After the 25th, done=1 and LEDs=1000.
- Hold without ack: ack=0 for 100 cycles in PRESENT -> window_data and window_ready stable.
- Abort: assert reset at store 800 of LOAD -> IDLE next cycle, receive never pulses; a new en restarts addr at 65.

Source files
------------

// File: rtl/window_fetch_sequencer_if.sv
// window_fetch_sequencer_if: memory read port, correlator window handshake and status.
interface window_fetch_sequencer_if;
    logic                        en;
    logic [31:0]                 input_data;
    logic                        ack;
    logic [20:0]                 addr;
    logic [6:0]                  row;
    logic [6:0]                  col;
    logic [15:0][15:0][7:0]      window_data;
    logic                        window_ready;
    logic                        done;
    logic                        receive;
    logic [3:0]                  LEDs;
    modport master (
        output en, input_data, ack,
        input  addr, row, col, window_data, window_ready, done, receive, LEDs
    );
    modport slave (
        input  en, input_data, ack,
        output addr, row, col, window_data, window_ready, done, receive, LEDs
    );
endinterface

// File: rtl/window_fetch_sequencer.sv
// window_fetch_sequencer: loads an 80x80 image from word memory, then serves strided 16x16 windows.
module window_fetch_sequencer #(
    parameter int SET_INDEX     = 0,
    parameter int IMG_OFFSET    = 65,
    parameter int IMG_DIM       = 80,
    parameter int WORDS_PER_ROW = 20,
    parameter int WIN_DIM       = 16,
    parameter int STRIDE        = 16
) (
    input logic                     clk,
    input logic                     rst_n,
    window_fetch_sequencer_if.slave bus
);
    typedef enum logic [3:0] {
        S_IDLE    = 4'b0001,
        S_LOAD    = 4'b0010,
        S_PRESENT = 4'b0100,
        S_DONE    = 4'b1000
    } state_t;
    localparam logic [6:0] LAST_ROW = 7'(IMG_DIM - 1);
    localparam logic [6:0] LAST_COL = 7'(WORDS_PER_ROW - 1);
    localparam logic [7:0] ORG_MAX  = 8'(IMG_DIM - WIN_DIM);
    state_t     r_state, w_next;
    logic [6:0] r_row, r_col, r_sr, r_sc, r_or, r_oc;
    logic       r_iss, r_st_vld, r_gap, r_receive;
    logic [7:0] r_img [IMG_DIM][IMG_DIM];
    logic       w_last_iss, w_last_st, w_fire, w_col_wrap, w_row_wrap, w_start;
    logic [7:0] w_oc_nx, w_or_nx;
    logic [6:0] w_bc;
    assign w_last_iss = r_row == LAST_ROW && r_col == LAST_COL;
    assign w_last_st  = r_state == S_LOAD && r_st_vld && r_sr == LAST_ROW && r_sc == LAST_COL;
    assign w_fire     = r_state == S_PRESENT && !r_gap && bus.ack;
    assign w_oc_nx    = {1'b0, r_oc} + 8'(STRIDE);
    assign w_or_nx    = {1'b0, r_or} + 8'(STRIDE);
    assign w_col_wrap = w_oc_nx > ORG_MAX;
    assign w_row_wrap = w_or_nx > ORG_MAX;
    assign w_start    = (r_state == S_IDLE || r_state == S_DONE) && bus.en;
    assign w_bc       = 7'({r_sc, 2'b00});
    always_comb begin
        w_next = r_state;
        if (w_start) w_next = S_LOAD;
        if (w_last_st) w_next = S_PRESENT;
        if (w_fire && w_col_wrap && w_row_wrap) w_next = S_DONE;
    end
    always_ff @(posedge clk) begin
        if (rst_n) r_state <= S_IDLE;
        else r_state <= w_next;
    end
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_row     <= '0;
            r_col     <= '0;
            r_sr      <= '0;
            r_sc      <= '0;
            r_or      <= '0;
            r_oc      <= '0;
            r_iss     <= 1'b0;
            r_st_vld  <= 1'b0;
            r_gap     <= 1'b0;
            r_receive <= 1'b0;
        end else begin
            r_receive <= w_last_st;
            r_st_vld  <= r_state == S_LOAD && r_iss;
            r_sr      <= r_row;
            r_sc      <= r_col;
            r_gap     <= w_fire;
            if (w_start) begin
                r_row <= '0;
                r_col <= '0;
                r_iss <= 1'b1;
            end else if (r_state == S_LOAD && r_iss) begin
                r_iss <= !w_last_iss;
                if (!w_last_iss) begin
                    r_col <= r_col == LAST_COL ? 7'd0 : r_col + 7'd1;
                    r_row <= r_col == LAST_COL ? r_row + 7'd1 : r_row;
                end
            end
            if (w_last_st) begin
                r_or <= '0;
                r_oc <= '0;
            end else if (w_fire) begin
                r_oc <= w_col_wrap ? 7'd0 : w_oc_nx[6:0];
                if (w_col_wrap) r_or <= w_or_nx[6:0];
            end
        end
    end
    // Stored word lands big-endian: input_data[31:24] is the leftmost byte.
    always_ff @(posedge clk) begin
        if (!rst_n && r_state == S_LOAD && r_st_vld)
            for (int k = 0; k < 4; k++)
                r_img[r_sr][w_bc + 7'(k)] <= bus.input_data[31 - 8*k -: 8];
    end
    for (genvar r = 0; r < WIN_DIM; r++) begin : g_r
        for (genvar c = 0; c < WIN_DIM; c++) begin : g_c
            assign bus.window_data[r][c] = r_img[r_or + 7'(r)][r_oc + 7'(c)];
        end
    end
    assign bus.addr         = 21'(SET_INDEX * 1665 + IMG_OFFSET)
                            + 21'(r_row) * 21'(WORDS_PER_ROW) + 21'(r_col);
    assign bus.row          = r_row;
    assign bus.col          = r_col;
    assign bus.window_ready = r_state == S_PRESENT && !r_gap;
    assign bus.done         = r_state == S_DONE;
    assign bus.receive      = r_receive;
    assign bus.LEDs         = r_state;
endmodule

// File: tb/tb_window_fetch_sequencer.sv
// tb_window_fetch_sequencer: directed load, window walk, hold and abort checks.
module tb_window_fetch_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   n_vec = 0;
    int   n_bad = 0;
    always #5 clk = ~clk;
    window_fetch_sequencer_if bus();
    window_fetch_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    // Memory word 65+k holds k, returned one cycle after the address.
    always @(posedge clk) bus.input_data <= 32'(bus.addr) - 32'd65;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    function automatic logic [7:0] img_byte(input int r, input int c);
        logic [31:0] w;
        w = 32'(r * 20 + c / 4);
        return w[31 - 8 * (c % 4) -: 8];
    endfunction
    function automatic int win_errs(input int orr, input int oc);
        int e = 0;
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++)
                if (bus.window_data[r][c] !== img_byte(orr + r, oc + c)) e++;
        return e;
    endfunction
    function automatic logic [31:0] win_word(input int r, input int c0);
        return {bus.window_data[r][c0], bus.window_data[r][c0+1],
                bus.window_data[r][c0+2], bus.window_data[r][c0+3]};
    endfunction
    initial begin
        logic [2047:0] snap;
        int bad_addr, rcv_at, rcv_cnt, chg, rdy_bad, gap_bad, werr;
        bus.en = 1'b0;
        bus.ack = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", bus.window_ready, 0);
        check("rst_done", bus.done, 0);
        check("rst_leds", bus.LEDs, 4'b0001);
        check("rst_addr", bus.addr, 65);
        check("rst_receive", bus.receive, 0);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_hold_leds", bus.LEDs, 4'b0001);
        bus.en = 1'b1;
        @(negedge clk);
        bus.en = 1'b0;
        bad_addr = 0; rcv_at = -1; rcv_cnt = 0;
        for (int i = 1; i <= 1700; i++) begin
            if (i <= 1600 && bus.addr !== 21'(65 + i - 1)) bad_addr++;
            if (bus.receive) begin
                rcv_cnt++;
                if (rcv_at < 0) rcv_at = i - 1;
            end
            if (i < 1700) @(negedge clk);
        end
        check("addr_sweep_errs", bad_addr, 0);
        check("receive_cycle", rcv_at, 1601);
        check("receive_count", rcv_cnt, 1);
        check("row_hold", bus.row, 79);
        check("col_hold", bus.col, 19);
        check("present_leds", bus.LEDs, 4'b0100);
        check("present_ready", bus.window_ready, 1);
        check("win0_r0_c0", win_word(0, 0), 32'h0000_0000);
        check("win0_r0_c4", win_word(0, 4), 32'h0000_0001);
        check("win0_r1_c0", win_word(1, 0), 32'h0000_0014);
        check("win0_full", win_errs(0, 0), 0);
        snap = bus.window_data;
        chg = 0;
        repeat (100) begin
            @(negedge clk);
            if (bus.window_data !== snap || bus.window_ready !== 1'b1) chg++;
        end
        check("hold_no_ack", chg, 0);
        bus.ack = 1'b1;
        rdy_bad = 0; gap_bad = 0; werr = 0;
        for (int w = 0; w < 25; w++) begin
            if (bus.window_ready !== 1'b1) rdy_bad++;
            werr += win_errs(16 * (w / 5), 16 * (w % 5));
            if (w == 1) check("win1_r0_c0", win_word(0, 0), 32'h0000_0004);
            if (w == 5) check("win5_r0_c0", win_word(0, 0), 32'h0000_0140);
            @(negedge clk);
            if (w < 24) begin
                if (bus.window_ready !== 1'b0) gap_bad++;
                @(negedge clk);
            end
        end
        check("walk_ready_errs", rdy_bad, 0);
        check("walk_gap_errs", gap_bad, 0);
        check("walk_data_errs", werr, 0);
        check("done_flag", bus.done, 1);
        check("done_leds", bus.LEDs, 4'b1000);
        check("done_ready", bus.window_ready, 0);
        bus.ack = 1'b0;
        repeat (5) @(negedge clk);
        check("done_hold", bus.done, 1);
        bus.en = 1'b1;
        @(negedge clk);
        bus.en = 1'b0;
        check("restart_addr", bus.addr, 65);
        check("restart_done_clr", bus.done, 0);
        rcv_cnt = 0;
        repeat (800) begin
            @(negedge clk);
            if (bus.receive) rcv_cnt++;
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_leds", bus.LEDs, 4'b0001);
        check("abort_addr", bus.addr, 65);
        rst_n = 1'b0;
        repeat (1700) begin
            @(negedge clk);
            if (bus.receive) rcv_cnt++;
        end
        check("abort_no_receive", rcv_cnt, 0);
        check("abort_idle_leds", bus.LEDs, 4'b0001);
        bus.en = 1'b1;
        @(negedge clk);
        bus.en = 1'b0;
        check("reload_addr0", bus.addr, 65);
        @(negedge clk);
        check("reload_addr1", bus.addr, 66);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
